multi_channel_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit either-edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable number of stable samples, and detects rising, falling or either edges under a per-channel mode. Events produce a one-cycle pulse, a sticky flag with write-one-to-clear, and a saturating event counter. The block sits between raw pin or status inputs and the interrupt and status logic.

---
 rtl/multi_channel_edge_detector.sv | 89 ++++++++
 tb/tb_multi_channel_edge_detector.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_edge_detector.sv
// Multi-channel glitch-filtered edge detector: per channel sync -> filter -> level
// -> edge qualify, with one-cycle rise/fall pulses, sticky flags and saturating counters.
module multi_channel_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         din,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr,
  output logic [CH-1:0]         rise,
  output logic [CH-1:0]         fall,
  output logic [CH-1:0]         pulse,
  output logic [CH-1:0]         sticky,
  output logic [CH*CNT_W-1:0]   count,
  output logic                  any_event
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             synced;
    logic             level_q;
    logic [FW-1:0]    filt_q;
    logic             rise_q;
    logic             fall_q;
    logic             pulse_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ch_mode;
    logic             flip;

    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = din[i];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din[i];
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end

    assign ch_mode = mode[2*i +: 2];
    // Level flips on the edge where the mismatch run would reach FILT_LEN.
    assign flip    = (synced != level_q) && (filt_q == FILT_LAST);

    always_ff @(posedge clk) begin
      if (!rst) begin
        level_q  <= 1'b0;
        filt_q   <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (synced == level_q || flip) filt_q <= '0;
        else                           filt_q <= filt_q + 1'b1;
        if (flip) level_q <= ~level_q;
        rise_q  <= flip && !level_q && ch_mode[0];
        fall_q  <= flip &&  level_q && ch_mode[1];
        pulse_q <= flip && (level_q ? ch_mode[1] : ch_mode[0]);
        // A pulse coinciding with clr survives the clear so no event is lost.
        if (clr[i])       sticky_q <= pulse_q;
        else if (pulse_q) sticky_q <= 1'b1;
        if (clr[i])                         cnt_q <= CNT_W'(pulse_q);
        else if (pulse_q && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
      end
    end

    assign rise[i]                   = rise_q;
    assign fall[i]                   = fall_q;
    assign pulse[i]                  = pulse_q;
    assign sticky[i]                 = sticky_q;
    assign count[CNT_W*i +: CNT_W]   = cnt_q;
  end

  assign any_event = |pulse;

endmodule

// File: tb/tb_multi_channel_edge_detector.sv
// Directed bench for multi_channel_edge_detector: default instance plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
module tb_multi_channel_edge_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic [7:0]  mode;
  logic [3:0]  clr;
  logic [3:0]  rise, fall, pulse, sticky;
  logic [31:0] count;
  logic        any_event;
  logic [3:0]  s_rise, s_fall, s_pulse, s_sticky;
  logic [15:0] s_count;
  logic        s_any_event;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_edge_detector dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .rise(rise), .fall(fall), .pulse(pulse), .sticky(sticky),
    .count(count), .any_event(any_event)
  );

  multi_channel_edge_detector #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .rise(s_rise), .fall(s_fall), .pulse(s_pulse), .sticky(s_sticky),
    .count(s_count), .any_event(s_any_event)
  );

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with inputs already high
    rst = 1'b0; din = 4'hF; mode = 8'hFF; clr = 4'h0;
    tick(3);
    chk("rst_rise", {28'd0, rise}, 32'h0);
    chk("rst_sticky", {28'd0, sticky}, 32'h0);
    chk("rst_count", count, 32'h0);
    chk("rst_any", {31'd0, any_event}, 32'h0);
    rst = 1'b1;
    tick(4);
    chk("post_rst_e4_rise", {28'd0, rise}, 32'h0);
    tick(1);
    chk("post_rst_e5_rise", {28'd0, rise}, 32'hF);
    chk("post_rst_e5_pulse", {28'd0, pulse}, 32'hF);
    chk("post_rst_e5_any", {31'd0, any_event}, 32'h1);
    chk("post_rst_e5_sticky", {28'd0, sticky}, 32'h0);
    tick(1);
    chk("post_rst_rise_gone", {28'd0, rise}, 32'h0);
    chk("post_rst_sticky", {28'd0, sticky}, 32'hF);
    chk("post_rst_count", count, 32'h01010101);

    // All channels fall
    din = 4'h0;
    tick(5);
    chk("all_fall", {28'd0, fall}, 32'hF);
    tick(1);
    chk("all_fall_count", count, 32'h02020202);
    tick(3);

    // Glitch of 2 cycles on ch0 is rejected
    din = 4'h1;
    tick(2);
    din = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("glitch_pulse", {28'd0, pulse}, 32'h0);
    end
    chk("glitch_count", count, 32'h02020202);

    // 3-cycle excursion on ch0 is accepted
    din = 4'h1;
    tick(3);
    din = 4'h0;
    tick(1);
    chk("acc_e4_rise", {28'd0, rise}, 32'h0);
    tick(1);
    chk("acc_e5_rise", {28'd0, rise}, 32'h1);
    tick(3);
    chk("acc_fall", {28'd0, fall}, 32'h1);
    tick(1);
    chk("acc_count", count, 32'h02020204);
    tick(3);

    // ch1 rising-only mode
    mode = 8'hF7;
    din = 4'h2;
    tick(5);
    chk("mode01_rise", {28'd0, rise}, 32'h2);
    tick(1);
    din = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("mode01_nofall", {28'd0, pulse}, 32'h0);
    end
    chk("mode01_count", count, 32'h02020304);

    // ch1 off: level tracks but no activity
    mode = 8'hF3;
    din = 4'h2;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("mode00_hi_pulse", {28'd0, pulse}, 32'h0);
    end
    din = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("mode00_lo_pulse", {28'd0, pulse}, 32'h0);
    end
    mode = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("reenable_pulse", {28'd0, pulse}, 32'h0);
    end
    chk("mode00_count", count, 32'h02020304);
    chk("mode00_sticky", {28'd0, sticky}, 32'hF);

    // clr collides with a new event on ch2
    din = 4'h4;
    tick(5);
    chk("clr_col_rise", {28'd0, rise}, 32'h4);
    clr = 4'h4;
    tick(1);
    clr = 4'h0;
    chk("clr_col_sticky", {28'd0, sticky}, 32'hF);
    chk("clr_col_count", count, 32'h02010304);
    clr = 4'h4;
    tick(1);
    clr = 4'h0;
    chk("clr_only_sticky", {28'd0, sticky}, 32'hB);
    chk("clr_only_count", count, 32'h02000304);

    // 20 accepted rising (and falling) edges on ch3
    for (int k = 0; k < 20; k++) begin
      din = 4'hC;
      tick(5);
      chk("sat_rise", {28'd0, rise}, 32'h8);
      chk("sat_small_rise", {28'd0, s_rise}, 32'h8);
      din = 4'h4;
      tick(5);
      chk("sat_fall", {28'd0, fall}, 32'h8);
    end
    tick(1);
    chk("sat_count_w8", count, 32'h2A000304);
    chk("sat_count_w4", {16'd0, s_count}, 32'h0000F034);

    // Reset in the middle of a ch0 filter run
    din = 4'h5;
    tick(3);
    din = 4'h1;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("midrst_rise", {28'd0, rise}, 32'h0);
    chk("midrst_sticky", {28'd0, sticky}, 32'h0);
    chk("midrst_count", count, 32'h0);
    chk("midrst_small_count", {16'd0, s_count}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("midrst_wait_pulse", {28'd0, pulse}, 32'h0);
    end
    tick(1);
    chk("midrst_rise_lat5", {28'd0, rise}, 32'h1);
    tick(1);
    chk("midrst_final_count", count, 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
